// File: rtl/keypad_lock_ctl.sv
// Passcode lock controller: turns debounced key events into a CODE_LEN-digit
// entry, checks it against LOCK_CODE, and manages open, fail counting,
// entry timeout and timed lockout. display_code feeds the 6-digit display mux
// (nibble 5 = leftmost, 4'hF = blank).
module keypad_lock_ctl #(
  parameter int          CODE_LEN       = 4,
  parameter logic [23:0] LOCK_CODE      = 24'h001234,
  parameter int          MAX_FAIL       = 3,
  parameter int          OPEN_CYCLES    = 1000,
  parameter int          LOCKOUT_CYCLES = 4000,
  parameter int          TIMEOUT_CYCLES = 2000,
  parameter int          TW             = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        press_valid,
  input  logic [3:0]  scan_code,
  output logic [23:0] display_code,
  output logic        unlocked,
  output logic        alarm,
  output logic [1:0]  fail_cnt,
  output logic [2:0]  digit_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_t;

  // Terminal timer values: a state lasting N cycles leaves when timer == N-1.
  localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    CODE_LEN_V   = 3'(CODE_LEN);
  localparam logic [1:0]    MAX_FAIL_V   = 2'(MAX_FAIL);
  localparam logic [23:0]   BLANK_DISP   = 24'hFFFFFF;
  localparam logic [23:0]   OPEN_DISP    = 24'h888888;

  state_t        state_reg, state_next;
  logic [23:0]   display_reg, display_next;
  logic          unlocked_reg, unlocked_next;
  logic          alarm_reg, alarm_next;
  logic [1:0]    fail_cnt_reg, fail_cnt_next;
  logic [2:0]    digit_cnt_reg, digit_cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          pv_q_reg;

  logic          key_event;
  logic [5:0]    nib_match;
  logic          code_match;
  logic [1:0]    fail_inc;

  // Rising edge of a qualified digit press; non-digit codes still update
  // pv_q_reg, so holding a bad key never re-arms a later edge.
  assign key_event = press_valid & ~pv_q_reg & (scan_code <= 4'd9);

  // Per-nibble compare of the entered digits; nibbles above CODE_LEN are
  // don't-care so shorter codes ignore the upper display positions.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cmp
      if (gi < CODE_LEN) begin : g_used
        assign nib_match[gi] = (display_reg[4*gi +: 4] == LOCK_CODE[4*gi +: 4]);
      end else begin : g_unused
        assign nib_match[gi] = 1'b1;
      end
    end
  endgenerate

  assign code_match = &nib_match;

  // Saturating increment so fail_cnt can never wrap past MAX_FAIL.
  assign fail_inc = (fail_cnt_reg >= MAX_FAIL_V) ? MAX_FAIL_V : fail_cnt_reg + 2'd1;

  // State and output registers; reset returns everything to the blank idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      display_reg   <= BLANK_DISP;
      unlocked_reg  <= 1'b0;
      alarm_reg     <= 1'b0;
      fail_cnt_reg  <= 2'd0;
      digit_cnt_reg <= 3'd0;
      timer_reg     <= '0;
      pv_q_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      display_reg   <= display_next;
      unlocked_reg  <= unlocked_next;
      alarm_reg     <= alarm_next;
      fail_cnt_reg  <= fail_cnt_next;
      digit_cnt_reg <= digit_cnt_next;
      timer_reg     <= timer_next;
      pv_q_reg      <= press_valid;
    end
  end

  // Next-state and next-output logic for the lock sequence.
  always_comb begin
    state_next     = state_reg;
    display_next   = display_reg;
    fail_cnt_next  = fail_cnt_reg;
    digit_cnt_next = digit_cnt_reg;
    timer_next     = timer_reg;

    case (state_reg)
      ST_IDLE: begin
        if (key_event) begin
          display_next   = {BLANK_DISP[19:0], scan_code};
          digit_cnt_next = 3'd1;
          state_next     = (CODE_LEN_V == 3'd1) ? ST_CHECK : ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        // A digit arriving on the expiry cycle takes priority over the timeout.
        if (key_event) begin
          display_next   = {display_reg[19:0], scan_code};
          digit_cnt_next = digit_cnt_reg + 3'd1;
          timer_next     = '0;
          if (digit_cnt_reg + 3'd1 == CODE_LEN_V) begin
            state_next = ST_CHECK;
          end
        end else if (timer_reg == TIMEOUT_LAST) begin
          state_next     = ST_IDLE;
          display_next   = BLANK_DISP;
          digit_cnt_next = 3'd0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      ST_CHECK: begin
        if (code_match) begin
          state_next    = ST_OPEN;
          fail_cnt_next = 2'd0;
          display_next  = OPEN_DISP;
        end else begin
          state_next = ST_FAIL;
        end
      end

      ST_OPEN: begin
        if (timer_reg == OPEN_LAST) begin
          state_next     = ST_IDLE;
          display_next   = BLANK_DISP;
          digit_cnt_next = 3'd0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      ST_FAIL: begin
        fail_cnt_next  = fail_inc;
        digit_cnt_next = 3'd0;
        if (fail_inc == MAX_FAIL_V) begin
          state_next   = ST_LOCKOUT;
          display_next = {20'hFFFFF, 2'b00, fail_inc};
        end else begin
          state_next   = ST_IDLE;
          display_next = BLANK_DISP;
        end
      end

      ST_LOCKOUT: begin
        if (timer_reg == LOCKOUT_LAST) begin
          state_next     = ST_IDLE;
          fail_cnt_next  = 2'd0;
          display_next   = BLANK_DISP;
          digit_cnt_next = 3'd0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        display_next   = BLANK_DISP;
        digit_cnt_next = 3'd0;
      end
    endcase

    // Every state entry starts its timer from zero.
    if (state_next != state_reg) begin
      timer_next = '0;
    end
  end

  // unlocked/alarm follow the next state so they switch on the same edge as it.
  always_comb begin
    unlocked_next = (state_next == ST_OPEN);
    alarm_next    = (state_next == ST_LOCKOUT);
  end

  assign display_code = display_reg;
  assign unlocked     = unlocked_reg;
  assign alarm        = alarm_reg;
  assign fail_cnt     = fail_cnt_reg;
  assign digit_cnt    = digit_cnt_reg;

endmodule

// File: tb/tb_keypad_lock_ctl.sv
// Directed bench for keypad_lock_ctl: correct code, held/non-digit keys,
// failures and lockout, timeout, event/timeout collision, reset mid-operation.
module tb_keypad_lock_ctl;

  localparam int OPEN_N    = 1000;
  localparam int LOCKOUT_N = 4000;
  localparam int TIMEOUT_N = 2000;

  logic        clk;
  logic        rst;
  logic        press_valid;
  logic [3:0]  scan_code;
  logic [23:0] display_code;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  fail_cnt;
  logic [2:0]  digit_cnt;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] model_disp;
  logic [2:0]  model_cnt;

  keypad_lock_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .press_valid  (press_valid),
    .scan_code    (scan_code),
    .display_code (display_code),
    .unlocked     (unlocked),
    .alarm        (alarm),
    .fail_cnt     (fail_cnt),
    .digit_cnt    (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded loop is ever bypassed.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_idle();
    model_disp = 24'hFFFFFF;
    model_cnt  = 3'd0;
  endtask

  // One key press: expected display pushed when driven, popped after the edge.
  task automatic press(input logic [3:0] code, input int hold, input int gap);
    logic [23:0] e;
    logic [23:0] got;
    e = (code <= 4'd9) ? {model_disp[19:0], code} : model_disp;
    if (code <= 4'd9) model_cnt = model_cnt + 3'd1;
    exp_q.push_back(e);
    press_valid = 1'b1;
    scan_code   = code;
    tick();
    got = exp_q.pop_front();
    chk("disp_evt", display_code, got);
    chk("digit_evt", digit_cnt, model_cnt);
    model_disp = e;
    for (int i = 1; i < hold; i++) tick();
    press_valid = 1'b0;
    scan_code   = 4'hF;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a, 6, 10);
    press(b, 6, 10);
    press(c, 6, 10);
    press(d, 1, 0);
  endtask

  // Called in the CHECK cycle after a correct code; measures the open window.
  task automatic run_open();
    int n;
    chk("check_unlk", unlocked, 1'b0);
    tick();
    chk("open_unlk", unlocked, 1'b1);
    chk("open_disp", display_code, 24'h888888);
    chk("open_fail", fail_cnt, 2'd0);
    n = 1;
    while (unlocked === 1'b1 && n < OPEN_N + 100) begin
      tick();
      if (unlocked === 1'b1) n++;
    end
    chk("open_len", n, OPEN_N);
    chk("open_end_disp", display_code, 24'hFFFFFF);
    chk("open_end_digit", digit_cnt, 3'd0);
    model_idle();
  endtask

  // Wrong code 9999; returns in IDLE (new_fail < 3) or first LOCKOUT cycle.
  task automatic wrong_attempt(input logic [1:0] new_fail);
    logic [1:0] old_fail;
    old_fail = new_fail - 2'd1;
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    tick();
    chk("fail_state_disp", display_code, 24'hFF9999);
    chk("fail_state_cnt", fail_cnt, old_fail);
    tick();
    chk("fail_cnt", fail_cnt, new_fail);
    if (new_fail < 2'd3) begin
      chk("fail_idle_disp", display_code, 24'hFFFFFF);
      chk("fail_idle_alarm", alarm, 1'b0);
      chk("fail_idle_digit", digit_cnt, 3'd0);
    end else begin
      chk("lock_alarm", alarm, 1'b1);
      chk("lock_disp", display_code, 24'hFFFFF3);
    end
    model_idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_disp"}, display_code, 24'hFFFFFF);
    chk({tag, "_unlk"}, unlocked, 1'b0);
    chk({tag, "_alarm"}, alarm, 1'b0);
    chk({tag, "_fail"}, fail_cnt, 2'd0);
    chk({tag, "_digit"}, digit_cnt, 3'd0);
  endtask

  initial begin
    int n;
    logic ok;
    rst = 1'b1;
    press_valid = 1'b0;
    scan_code = 4'hF;
    model_idle();
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Correct code opens for exactly OPEN_N cycles.
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("code_disp", display_code, 24'hFF1234);
    run_open();

    // Held key gives one digit; non-digit code changes nothing.
    press(4'd5, 50, 10);
    chk("held_digit", digit_cnt, 3'd1);
    chk("held_disp", display_code, 24'hFFFFF5);
    press(4'hF, 6, 10);
    chk("nondigit_digit", digit_cnt, 3'd1);
    n = 0;
    while (digit_cnt !== 3'd0 && n < TIMEOUT_N + 100) begin
      tick();
      n++;
    end
    chk("held_timeout_disp", display_code, 24'hFFFFFF);
    model_idle();

    // First failure.
    wrong_attempt(2'd1);

    // Timeout after two digits: exact expiry, fail_cnt untouched.
    press(4'd1, 6, 10);
    press(4'd2, 1, 0);
    for (int i = 0; i < TIMEOUT_N - 1; i++) tick();
    chk("pre_timeout_disp", display_code, 24'hFFFF12);
    chk("pre_timeout_digit", digit_cnt, 3'd2);
    tick();
    chk("timeout_disp", display_code, 24'hFFFFFF);
    chk("timeout_digit", digit_cnt, 3'd0);
    chk("timeout_fail", fail_cnt, 2'd1);
    model_idle();

    // Digit lands on the expiry cycle: digit wins, entry continues to OPEN.
    press(4'd1, 1, 0);
    for (int i = 0; i < TIMEOUT_N - 1; i++) tick();
    press(4'd2, 6, 10);
    chk("collide_disp", display_code, 24'hFFFF12);
    press(4'd3, 6, 10);
    press(4'd4, 1, 0);
    run_open();

    // Three failures lead to lockout; keys are ignored throughout.
    wrong_attempt(2'd1);
    wrong_attempt(2'd2);
    wrong_attempt(2'd3);
    n = 1;
    ok = 1'b1;
    while (alarm === 1'b1 && n < LOCKOUT_N + 100) begin
      press_valid = ((n % 20) < 5);
      scan_code   = 4'd7;
      tick();
      if (alarm === 1'b1) begin
        n++;
        if (display_code !== 24'hFFFFF3 || unlocked !== 1'b0) ok = 1'b0;
      end
    end
    press_valid = 1'b0;
    scan_code   = 4'hF;
    chk("lock_len", n, LOCKOUT_N);
    chk("lock_keys_ignored", ok, 1'b1);
    chk("lock_end_fail", fail_cnt, 2'd0);
    chk("lock_end_disp", display_code, 24'hFFFFFF);
    chk("lock_end_digit", digit_cnt, 3'd0);
    tick();

    // Reset during OPEN, then a normal open.
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    chk("pre_rst_unlk", unlocked, 1'b1);
    for (int i = 1; i < 500; i++) tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_open");
    rst = 1'b0;
    model_idle();
    tick();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    run_open();

    // Reset during LOCKOUT, then a normal open.
    wrong_attempt(2'd1);
    wrong_attempt(2'd2);
    wrong_attempt(2'd3);
    for (int i = 0; i < 100; i++) tick();
    chk("pre_rst_alarm", alarm, 1'b1);
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_lock");
    rst = 1'b0;
    model_idle();
    tick();
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    run_open();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
